text_buffer: RTL and testbench
==============================

# text_buffer

Parametrised character store for the VGA console. It holds a COLS×ROWS grid of 8-bit glyph codes and serves the glyph fetch stage through a 1-cycle registered read port. It also accepts a byte stream from the host side (UART/USB bridge) and interprets it as terminal output, with a cursor, control characters, line wrap and hardware scrolling. The block sits between the input byte source and the font/pixel pipeline.

## Interface
- COLS, default 80: characters per row.
- ROWS, default 30: rows per screen.
- X_W, default $clog2(COLS): width of x coordinates.
- Y_W, default $clog2(ROWS): width of y coordinates.
- clk  input  1  sole clock.
- rst  input  1  reset, synchronous and active-high.
- x  input  X_W  read column (screen coordinates).
- y  input  Y_W  read row (screen coordinates).
- glyph  output  8  registered glyph at (x, y).
- in_data  input  8  byte from the host stream.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a byte this cycle.
- cursor_x  output  X_W  current cursor column.
- cursor_y  output  Y_W  current cursor row (screen coordinates).
- busy  output  1  a clear is in progress; equals !in_ready.

## Operation
- Storage is a single COLS*ROWS×8 RAM with one read port and one write port.
  - Physical address = ((y + top) mod ROWS)*COLS + x.
  - top is an internal Y_W-bit row offset.
- Read path:
  - glyph <= mem[addr(x, y)] on every clk edge.
  - If x ≥ COLS or y ≥ ROWS, glyph <= 0x20.
  - When a read and a write hit the same cell in the same cycle, the read returns the old data.
- FSM states:
  - CLEAR_ALL: writes 0x20 to every cell. It uses a counter from 0 to COLS*ROWS-1, one cell per cycle, then goes to IDLE.
  - IDLE: in_ready=1. A byte is accepted when in_valid && in_ready.
  - CLEAR_ROW: writes 0x20 to the COLS cells of one physical row, then returns to IDLE.
- Byte handling in IDLE:
  - 0x20–0x7E: write the byte at the cursor.
    - If cursor_x < COLS-1, cursor_x++.
    - Otherwise perform a newline.
  - 0x0A (LF): cursor_x=0, then perform a newline.
  - 0x0D (CR): cursor_x=0.
  - 0x08 (BS): if cursor_x > 0, cursor_x--. The cell is not erased.
  - Any other byte: consumed and ignored. The cursor is unchanged.
- Newline rules:
  - If cursor_y < ROWS-1: cursor_y++ and stay in IDLE. No clearing.
  - If cursor_y == ROWS-1: the behaviour depends on the configuration (see below), then the FSM enters CLEAR_ROW.
- Arithmetic:
  - The top increment wraps from ROWS-1 to 0. It is not a power-of-two wrap.
  - All row math is done mod ROWS with explicit compare-and-subtract.
- Reset values:
  - glyph=0x20, cursor_x=0, cursor_y=0, top=0, in_ready=0, busy=1.
  - State is CLEAR_ALL, with the clear counter at 0.
- Reset asserted mid-operation aborts any clear, any pending write and any cursor update. The block restarts CLEAR_ALL from cell 0.

## Timing
- Read latency: glyph reflects (x, y) sampled at edge N, valid after edge N, i.e. 1 cycle.
- Write latency: an accepted printable byte is written to RAM at the acceptance edge. A read of that cell issued in the next cycle returns the new byte.
- Cursor outputs update at the acceptance edge.
- After rst deasserts, in_ready rises exactly COLS*ROWS cycles later (2400 at the defaults).
- Newline on the last row:
  - in_ready drops the cycle after acceptance and stays low for exactly COLS cycles.
  - top and cursor update at the acceptance edge, so the display scrolls before the clear finishes.
- in_data is only sampled when in_ready=1. The source must hold in_valid/in_data until accepted.

## Configuration
- BUFFER_SCROLL_EN defined:
  - A newline on the last row does top <= (top+1) mod ROWS and keeps cursor_y=ROWS-1.
  - CLEAR_ROW clears the physical row previously at the top, which is now the bottom screen row.
- BUFFER_SCROLL_EN undefined:
  - top is constant 0.
  - A newline on the last row wraps cursor_y to 0, and CLEAR_ROW clears screen row 0.

## Test plan
- Reset, then wait: in_ready=0 for 2400 cycles, then 1. Reading every (x, y) returns 0x20. Cursor is (0,0).
- Stream "Hi" then read (0,0) and (1,0) -> 0x48 and 0x69. cursor_x=2.
- Send 80 × 'A' -> row 0 is all 0x41 and the cursor is (0,1). Then send BS -> cursor stays (0,1).
- Send "ab", CR, "X" -> (0,0)=0x58, (1,0)=0x62.
- With BUFFER_SCROLL_EN:
  - Write "T" on row 0 and "B" on row 29.
  - Send LF from the last row -> in_ready low for 80 cycles. Screen row 28 reads 'B', row 29 reads 0x20, and 'T' is gone. cursor_y=29.
  - Without the macro, the same stimulus -> cursor (0,0), row 0 cleared, row 29 still 'B'.
- Assert rst for 1 cycle midway through CLEAR_ROW -> CLEAR_ALL restarts. in_ready returns 2400 cycles later and the whole screen reads 0x20.

Source files
------------

// File: rtl/text_buffer.sv
// COLS x ROWS glyph store with a terminal-style byte writer (cursor, CR/LF/BS, wrap, optional scroll via BUFFER_SCROLL_EN).
// glyph is registered (1 cycle); in_ready is low during CLEAR_ALL (COLS*ROWS cycles) and CLEAR_ROW (COLS cycles).
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int X_W  = $clog2(COLS),
  parameter int Y_W  = $clog2(ROWS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [7:0]     glyph,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int A_W   = $clog2(CELLS);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  state_t         state, state_nxt;
  logic [A_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [X_W-1:0] clr_col, clr_col_nxt;
  logic [Y_W-1:0] clr_row, clr_row_nxt;
  logic [Y_W-1:0] top, top_nxt;
  logic [X_W-1:0] cx_nxt;
  logic [Y_W-1:0] cy_nxt;
  logic           wr_en;
  logic [A_W-1:0] wr_addr;
  logic [7:0]     wr_dat;
  logic           newline;
  logic           rd_in_range;
  logic [A_W-1:0] rd_addr;

  logic [7:0] mem [CELLS];

  // Both operands must already be < ROWS, so one conditional subtract suffices.
  function automatic logic [Y_W-1:0] wrap_row(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    logic [Y_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (Y_W+1)'(ROWS)) s = s - (Y_W+1)'(ROWS);
    return s[Y_W-1:0];
  endfunction

  function automatic logic [A_W-1:0] cell_addr(input logic [Y_W-1:0] row, input logic [X_W-1:0] col);
    return A_W'(row) * A_W'(COLS) + A_W'(col);
  endfunction

  assign rd_in_range = ({1'b0, x} < (X_W+1)'(COLS)) && ({1'b0, y} < (Y_W+1)'(ROWS));
  assign rd_addr     = cell_addr(wrap_row(y, top), x);

  always_ff @(posedge clk) begin
    if (rst)              glyph <= SPACE;
    else if (rd_in_range) glyph <= mem[rd_addr];
    else                  glyph <= SPACE;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_dat;
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_col_nxt = clr_col;
    clr_row_nxt = clr_row;
    top_nxt     = top;
    cx_nxt      = cursor_x;
    cy_nxt      = cursor_y;
    wr_en       = 1'b0;
    wr_addr     = clr_cnt;
    wr_dat      = SPACE;
    newline     = 1'b0;
    case (state)
      CLEAR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        if (clr_cnt == A_W'(CELLS-1)) begin
          clr_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + A_W'(1);
        end
      end
      CLEAR_ROW: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row, clr_col);
        if (clr_col == X_W'(COLS-1)) begin
          clr_col_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          clr_col_nxt = clr_col + X_W'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(wrap_row(cursor_y, top), cursor_x);
            wr_dat  = in_data;
            if (cursor_x < X_W'(COLS-1)) begin
              cx_nxt = cursor_x + X_W'(1);
            end else begin
              cx_nxt  = '0;
              newline = 1'b1;
            end
          end else if (in_data == 8'h0A) begin
            cx_nxt  = '0;
            newline = 1'b1;
          end else if (in_data == 8'h0D) begin
            cx_nxt = '0;
          end else if (in_data == 8'h08) begin
            if (cursor_x != '0) cx_nxt = cursor_x - X_W'(1);
          end

          if (newline) begin
            if (cursor_y < Y_W'(ROWS-1)) begin
              cy_nxt = cursor_y + Y_W'(1);
            end else begin
`ifdef BUFFER_SCROLL_EN
              // The old top row becomes the new bottom row and is blanked.
              clr_row_nxt = top;
              top_nxt     = wrap_row(top, Y_W'(1));
`else
              clr_row_nxt = '0;
              cy_nxt      = '0;
`endif
              clr_col_nxt = '0;
              state_nxt   = CLEAR_ROW;
            end
          end
        end
      end
      default: state_nxt = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ALL;
      clr_cnt  <= '0;
      clr_col  <= '0;
      clr_row  <= '0;
      top      <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_col  <= clr_col_nxt;
      clr_row  <= clr_row_nxt;
      top      <= top_nxt;
      cursor_x <= cx_nxt;
      cursor_y <= cy_nxt;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed byte stream and reads; glyph reads are checked by a queue-based scoreboard.
module tb_text_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] x = '0;
  logic [4:0] y = '0;
  logic [7:0] glyph;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  text_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .glyph    (glyph),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic       rd_req = 1'b0;
  logic       rd_q   = 1'b0;
  logic [7:0] mon_exp;
  string      mon_nm;

  always @(posedge clk) rd_q <= rd_req;

  // Monitor: a read issued before posedge N is visible at the following negedge.
  always @(negedge clk) begin
    if (rd_q) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: glyph=%02h with no expected entry", glyph);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        if (glyph !== mon_exp) begin
          n_err++;
          $display("FAIL %s: glyph=%02h expected %02h", mon_nm, glyph, mon_exp);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic wait_ready(input int exp_low, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, exp_low);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_glyph", int'(glyph), 32'h20);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor_x", int'(cursor_x), 0);
    check("rst_cursor_y", int'(cursor_y), 0);
    rst = 1'b0;
    wait_ready(COLS*ROWS, "clear_all_cycles");
    check("ready_busy", int'(busy), 0);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready=0 expected 1 for byte %02h", b);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic read_cell(input int xx, input int yy, input logic [7:0] e, input string nm);
    @(negedge clk);
    x = 7'(xx);
    y = 5'(yy);
    rd_req = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic read_row(input int yy, input logic [7:0] e, input string nm);
    for (int xx = 0; xx < COLS; xx++) read_cell(xx, yy, e, nm);
  endtask

  task automatic read_screen(input logic [7:0] e, input string nm);
    for (int yy = 0; yy < ROWS; yy++) read_row(yy, e, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;

    do_reset();
    read_screen(8'h20, "init_clear");
    read_cell(80, 0, 8'h20, "oob_x");
    read_cell(0, 30, 8'h20, "oob_y");
    read_cell(127, 31, 8'h20, "oob_xy");

    send(8'h48);
    send(8'h69);
    read_cell(0, 0, 8'h48, "hi_H");
    read_cell(1, 0, 8'h69, "hi_i");
    check("hi_cursor_x", int'(cursor_x), 2);

    send(8'h0D);
    check("cr_cursor_x", int'(cursor_x), 0);
    for (int k = 0; k < COLS; k++) send(8'h41);
    read_row(0, 8'h41, "row0_A");
    check("wrap_cursor_x", int'(cursor_x), 0);
    check("wrap_cursor_y", int'(cursor_y), 1);
    send(8'h08);
    check("bs_col0_x", int'(cursor_x), 0);
    check("bs_col0_y", int'(cursor_y), 1);

    send(8'h61);
    send(8'h62);
    send(8'h0D);
    send(8'h58);
    read_cell(0, 1, 8'h58, "cr_over_X");
    read_cell(1, 1, 8'h62, "cr_keep_b");
    check("x_cursor_x", int'(cursor_x), 1);
    send(8'h08);
    check("bs_cursor_x", int'(cursor_x), 0);
    send(8'h07);
    check("ign_cursor_x", int'(cursor_x), 0);
    check("ign_cursor_y", int'(cursor_y), 1);
    read_cell(0, 1, 8'h58, "bs_no_erase");
    read_cell(2, 1, 8'h20, "row1_blank");

    for (int k = 0; k < 28; k++) send(8'h0A);
    check("lf_cursor_y", int'(cursor_y), 29);
    send(8'h42);
    read_cell(0, 29, 8'h42, "last_row_B");
    send(8'h0A);
    wait_ready(COLS, "clear_row_cycles");
`ifdef BUFFER_SCROLL_EN
    check("scroll_cursor_x", int'(cursor_x), 0);
    check("scroll_cursor_y", int'(cursor_y), 29);
    read_cell(0, 28, 8'h42, "scroll_B_up");
    read_row(29, 8'h20, "scroll_bottom_clear");
    read_cell(0, 0, 8'h58, "scroll_row1_X");
    read_cell(1, 0, 8'h62, "scroll_row1_b");
    send(8'h5A);
    read_cell(0, 29, 8'h5A, "scroll_write_Z");
`else
    check("wrap_y_cursor_x", int'(cursor_x), 0);
    check("wrap_y_cursor_y", int'(cursor_y), 0);
    read_row(0, 8'h20, "row0_cleared");
    read_cell(0, 29, 8'h42, "row29_keep_B");
    read_cell(0, 1, 8'h58, "row1_keep_X");
    send(8'h5A);
    read_cell(0, 0, 8'h5A, "wrap_write_Z");
`endif
    check("z_cursor_x", int'(cursor_x), 1);

    i = 0;
    while (cursor_y != 5'd29 && i < 40) begin
      send(8'h0A);
      i++;
    end
    check("pre_mid_cursor_y", int'(cursor_y), 29);
    send(8'h0A);
    repeat (5) @(negedge clk);
    check("mid_clear_busy", int'(in_ready), 0);
    do_reset();
    read_screen(8'h20, "mid_reset_clear");

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
